// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_scan_ctrl_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Widest display value the nibble helper accepts (16 digits).
  localparam int NIB_VEC_W = 64;

  function automatic logic [3:0] nibble(input logic [NIB_VEC_W-1:0] vec, input int idx);
    logic [NIB_VEC_W-1:0] sh;
    sh = vec >> (4 * idx);
    return sh[3:0];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load/ack handshake and display-mode control between a value producer and the scan controller.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] data_in;
  logic                  load;
  logic                  blank_lz;
  logic                  ack;

  modport master (
    output data_in,
    output load,
    output blank_lz,
    input  ack
  );

  modport slave (
    input  data_in,
    input  load,
    input  blank_lz,
    output ack
  );

endinterface

// File: rtl/display_scan_ctrl_display7.sv
// Hex to 7-segment decoder for a common-anode digit; seg = {g,f,e,d,c,b,a}, active low.
module display7 (
  input  logic [3:0] s_mux,
  output logic [6:0] seg
);

  // Glyph lookup, all sixteen hex values.
  always_comb begin
    seg = 7'h7F;
    case (s_mux)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit scan controller: blank slot + show slot per digit, frame-aligned
// commit of double-buffered values, optional leading-zero suppression.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS        = 4,
  parameter int TICKS_PER_DIGIT = 27000,
  parameter int BLANK_TICKS     = 270,
  localparam int DSEL_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   bus,
  output logic                 frame_done,
  output logic [DSEL_W-1:0]    digit_sel,
  output logic [3:0]           digit_val,
  output logic [N_DIGITS-1:0]  an,
  output logic [6:0]           seg
);

  localparam int DW      = 4 * N_DIGITS;
  localparam int MAX_LEN = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [DSEL_W-1:0] DSEL_ZERO  = DSEL_W'(0);
  localparam logic [DSEL_W-1:0] DSEL_ONE   = DSEL_W'(1);
  localparam logic [DSEL_W-1:0] DSEL_LAST  = DSEL_W'(N_DIGITS - 1);

  scan_state_t          state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [DSEL_W-1:0]    dsel_r, dsel_s;
  logic [DW-1:0]        pend_r, disp_r, disp_s;
  logic                 pending_r, pending_s;
  logic                 ack_r, ack_s;
  logic                 frame_done_r, frame_end_s;
  logic [N_DIGITS-1:0]  an_r, an_s, dark_s;
  logic [3:0]           digit_val_r, digit_val_s;
  logic                 all_zero_s;

  // Scan sequencing: blank/show slot timing and digit advance.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_ONE;
    dsel_s  = dsel_r;
    case (state_r)
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = SHOW;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = BLANK;
        end
      end
      SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_s = BLANK;
          cnt_s   = CNT_ZERO;
          if (dsel_r == DSEL_LAST) begin
            dsel_s = DSEL_ZERO;
          end else begin
            dsel_s = dsel_r + DSEL_ONE;
          end
        end else begin
          state_s = SHOW;
        end
      end
      default: begin
        state_s = BLANK;
        cnt_s   = CNT_ZERO;
        dsel_s  = DSEL_ZERO;
      end
    endcase
  end

  // Double buffer, commit decision and next-cycle output images.
  always_comb begin
    // Outputs are registered, so flag the final cycle of the frame one edge early.
    frame_end_s = (state_s == SHOW) && (cnt_s == SHOW_LAST) && (dsel_s == DSEL_LAST);
    ack_s       = frame_end_s && (pending_r || bus.load);
    // ack_r marks the frame's last cycle with a commit due; the swap happens as it ends.
    disp_s      = disp_r;
    if (ack_r) begin
      disp_s = pend_r;
    end else begin
      disp_s = disp_r;
    end
    pending_s = pending_r;
    if (bus.load) begin
      pending_s = 1'b1;
    end else if (ack_r) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end
    all_zero_s = 1'b1;
    dark_s     = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      all_zero_s = all_zero_s && (nibble(NIB_VEC_W'(disp_s), i) == 4'h0);
      dark_s[i]  = bus.blank_lz && all_zero_s;
    end
    an_s = '1;
    if ((state_s == SHOW) && !dark_s[dsel_s]) begin
      an_s[dsel_s] = 1'b0;
    end else begin
      an_s = '1;
    end
    digit_val_s = nibble(NIB_VEC_W'(disp_s), int'(dsel_s));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= BLANK;
      cnt_r        <= CNT_ZERO;
      dsel_r       <= DSEL_ZERO;
      pend_r       <= '0;
      disp_r       <= '0;
      pending_r    <= 1'b0;
      ack_r        <= 1'b0;
      frame_done_r <= 1'b0;
      an_r         <= '1;
      digit_val_r  <= 4'h0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      dsel_r       <= dsel_s;
      pend_r       <= bus.load ? bus.data_in : pend_r;
      disp_r       <= disp_s;
      pending_r    <= pending_s;
      ack_r        <= ack_s;
      frame_done_r <= frame_end_s;
      an_r         <= an_s;
      digit_val_r  <= digit_val_s;
    end
  end

  assign bus.ack    = ack_r;
  assign frame_done = frame_done_r;
  assign digit_sel  = dsel_r;
  assign digit_val  = digit_val_r;
  assign an         = an_r;

  display7 u_display7 (
    .s_mux (digit_val_r),
    .seg   (seg)
  );

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 4-digit, 4-tick show, 1-tick blank (20-cycle frame).
module tb_display_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_done;
  logic [1:0] digit_sel;
  logic [3:0] digit_val;
  logic [3:0] an;
  logic [6:0] seg;
  int         total;
  int         bad;

  display_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  display_scan_ctrl #(
    .N_DIGITS        (4),
    .TICKS_PER_DIGIT (4),
    .BLANK_TICKS     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .digit_sel  (digit_sel),
    .digit_val  (digit_val),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input int cyc);
    chk("rst_an", cyc, 16'(an), 16'hF);
    chk("rst_sel", cyc, 16'(digit_sel), 16'h0);
    chk("rst_val", cyc, 16'(digit_val), 16'h0);
    chk("rst_ack", cyc, 16'(bus.ack), 16'h0);
    chk("rst_fd", cyc, 16'(frame_done), 16'h0);
  endtask

  // One frame from cycle 0: shown = displayed value, lit = digits expected lit in SHOW.
  task automatic run_frame(input logic [15:0] shown, input logic [3:0] lit, input logic lz,
                           input logic ack_exp, input int lc1, input logic [15:0] lv1,
                           input int lc2, input logic [15:0] lv2, input int rc);
    logic [3:0]  e_an;
    logic [3:0]  e_val;
    logic [15:0] sh;
    int          slot;
    int          pos;
    bus.blank_lz = lz;
    for (int c = 0; c < 20; c++) begin
      slot = c / 5;
      pos  = c % 5;
      sh   = shown >> (4 * slot);
      e_val = sh[3:0];
      e_an  = 4'hF;
      if (pos != 0 && lit[slot]) e_an[slot] = 1'b0;
      chk("an", c, 16'(an), 16'(e_an));
      chk("digit_sel", c, 16'(digit_sel), 16'(slot));
      chk("digit_val", c, 16'(digit_val), 16'(e_val));
      chk("seg", c, 16'(seg), 16'(exp_seg(e_val)));
      chk("frame_done", c, 16'(frame_done), 16'(c == 19));
      chk("ack", c, 16'(bus.ack), 16'((c == 19) && ack_exp));
      bus.load    = (c == lc1) || (c == lc2);
      bus.data_in = (c == lc2) ? lv2 : lv1;
      rst         = (c == rc);
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      if (c == rc) begin
        chk_reset_state(c + 1);
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.data_in  = 16'h0000;
    bus.blank_lz = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_state(-1);
    rst = 1'b0;

    // Idle frame, then a load committed at the frame end.
    run_frame(16'h0000, 4'b1111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000, -1);
    run_frame(16'h0000, 4'b1111, 1'b0, 1'b1,  7, 16'h1234, -1, 16'h0000, -1);
    // Two loads in one frame: last wins, single ack.
    run_frame(16'h1234, 4'b1111, 1'b0, 1'b1,  3, 16'hAAAA,  9, 16'h00B5, -1);
    run_frame(16'h00B5, 4'b1111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000, -1);
    // Leading-zero suppression on 00B5, 0000, 1000.
    run_frame(16'h00B5, 4'b0011, 1'b1, 1'b1,  5, 16'h0000, -1, 16'h0000, -1);
    run_frame(16'h0000, 4'b0001, 1'b1, 1'b1,  2, 16'h1000, -1, 16'h0000, -1);
    run_frame(16'h1000, 4'b1111, 1'b1, 1'b0, -1, 16'h0000, -1, 16'h0000, -1);
    // Load in the frame-end cycle stays pending for a second ack.
    run_frame(16'h1000, 4'b1111, 1'b0, 1'b1,  5, 16'h1111, 19, 16'h2222, -1);
    run_frame(16'h1111, 4'b1111, 1'b0, 1'b1, -1, 16'h0000, -1, 16'h0000, -1);
    run_frame(16'h2222, 4'b1111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000, -1);
    // Reset mid-frame discards the pending load.
    run_frame(16'h2222, 4'b1111, 1'b0, 1'b0,  5, 16'h3333, -1, 16'h0000, 12);
    run_frame(16'h0000, 4'b1111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
